// File: rtl/accum_seq_ctrl.sv
// Sequencer for an 8-bit add/subtract accumulator: runs multiply as repeated
// addition and divide as repeated subtraction, with a START/DONE handshake.
module accum_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic             OP,
  input  logic [WIDTH-1:0] OPA,
  input  logic [WIDTH-1:0] OPB,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] B,
  output logic             S,
  output logic             E,
  output logic             ACC_CLR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] REM,
  output logic             ERR
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD, MUL_ADD, DIV_SUB, FINISH
  } state_t;

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic             op_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] cnt;
  logic             ovf;
  logic             div0;
  logic             q_ge;

  assign q_ge = (Q >= opb_q);

  // Datapath controls decode directly from state; DIV_SUB also looks at Q.
  always_comb begin
    B = '0;
    S = 1'b0;
    E = 1'b0;
    case (state)
      LOAD, MUL_ADD: begin
        B = opa_q;
        E = 1'b1;
      end
      DIV_SUB: begin
        if (q_ge) begin
          B = opb_q;
          S = 1'b1;
          E = 1'b1;
        end
      end
      default: ;
    endcase
    ACC_CLR = CLR || (state == CLEAR);
    BUSY    = (state != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state  <= IDLE;
      op_q   <= 1'b0;
      opa_q  <= '0;
      opb_q  <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      div0   <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= '0;
      REM    <= '0;
      ERR    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            op_q  <= OP;
            opa_q <= OPA;
            opb_q <= OPB;
            cnt   <= '0;
            ovf   <= 1'b0;
            div0  <= OP && (OPB == '0);
            state <= (OP && (OPB == '0)) ? FINISH : CLEAR;
          end
        end
        CLEAR: begin
          if (op_q)              state <= LOAD;
          else if (opb_q != '0)  state <= MUL_ADD;
          else                   state <= FINISH;
        end
        LOAD: state <= DIV_SUB;
        MUL_ADD: begin
          cnt <= cnt + ONE;
          // Overflow is judged on Q before this cycle's add lands.
          if (Q > (MAX - opa_q)) ovf <= 1'b1;
          if ((cnt + ONE) == opb_q) state <= FINISH;
        end
        DIV_SUB: begin
          if (q_ge) cnt   <= cnt + ONE;
          else      state <= FINISH;
        end
        FINISH: begin
          DONE  <= 1'b1;
          state <= IDLE;
          if (div0) begin
            RESULT <= MAX;
            REM    <= opa_q;
            ERR    <= 1'b1;
          end else if (op_q) begin
            RESULT <= cnt;
            REM    <= Q;
            ERR    <= ovf;
          end else begin
            RESULT <= Q;
            REM    <= '0;
            ERR    <= ovf;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Bench for accum_seq_ctrl: models the accumulator datapath, predicts each
// transaction's outcome and timing arithmetically, and checks every cycle.
module tb_accum_seq_ctrl;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       START = 1'b0;
  logic       OP = 1'b0;
  logic [7:0] OPA = '0;
  logic [7:0] OPB = '0;
  logic [7:0] acc = '0;
  logic [7:0] B;
  logic       S, E, ACC_CLR, BUSY, DONE, ERR;
  logic [7:0] RESULT, REM;

  accum_seq_ctrl #(.WIDTH(8)) dut (
    .CLK(CLK), .CLR(CLR), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
    .Q(acc), .B(B), .S(S), .E(E), .ACC_CLR(ACC_CLR), .BUSY(BUSY),
    .DONE(DONE), .RESULT(RESULT), .REM(REM), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Accumulator datapath the sequencer drives.
  always @(posedge CLK) begin
    if (ACC_CLR)  acc <= '0;
    else if (E)   acc <= S ? acc - B : acc + B;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Expected transaction, computed from operands alone.
  bit exp_active = 0;
  int exp_t0, exp_L, exp_res, exp_rem, exp_err;
  int exp_adds, exp_subs, exp_clrs, exp_addb, exp_subb;
  int n_adds, n_subs, n_clrs;
  int held_res = 0, held_rem = 0, held_err = 0;
  bit pin_on = 0;
  int pin_res, pin_rem, pin_err, pin_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      #2;
      if (CLR) begin
        exp_active = 0;
        held_res = 0; held_rem = 0; held_err = 0;
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_result", RESULT, 0);
        chk("rst_rem", REM, 0);
        chk("rst_err", ERR, 0);
        chk("rst_e", E, 0);
        chk("rst_b", B, 0);
        chk("rst_s", S, 0);
        chk("rst_accclr", ACC_CLR, 1);
      end else if (exp_active && cyc < exp_t0 + exp_L) begin
        chk("busy", BUSY, 1);
        chk("done_early", DONE, 0);
        chk("held_result", RESULT, held_res);
        chk("held_rem", REM, held_rem);
        chk("held_err", ERR, held_err);
        if (ACC_CLR) n_clrs++;
        if (E && !S) begin n_adds++; chk("add_b", B, exp_addb); end
        if (E && S)  begin n_subs++; chk("sub_b", B, exp_subb); end
      end else if (exp_active && cyc == exp_t0 + exp_L) begin
        chk("done", DONE, 1);
        chk("busy_end", BUSY, 0);
        held_res = exp_res; held_rem = exp_rem; held_err = exp_err;
        chk("result", RESULT, exp_res);
        chk("rem", REM, exp_rem);
        chk("err", ERR, exp_err);
        chk("n_adds", n_adds, exp_adds);
        chk("n_subs", n_subs, exp_subs);
        chk("n_clrs", n_clrs, exp_clrs);
        chk("e_idle", E, 0);
        if (pin_on) begin
          chk("pin_result", RESULT, pin_res);
          chk("pin_rem", REM, pin_rem);
          chk("pin_err", ERR, pin_err);
          chk("pin_latency", DONE ? (cyc - exp_t0) : -1, pin_lat);
        end
        exp_active = 0;
      end else begin
        chk("idle_busy", BUSY, 0);
        chk("idle_done", DONE, 0);
        chk("idle_e", E, 0);
        chk("idle_accclr", ACC_CLR, 0);
        chk("idle_result", RESULT, held_res);
        chk("idle_rem", REM, held_rem);
        chk("idle_err", ERR, held_err);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns one negedge later.
  task automatic start_txn(input int op, input int a, input int b);
    OP = op[0]; OPA = 8'(a); OPB = 8'(b); START = 1'b1;
    exp_addb = a; exp_subb = b;
    n_adds = 0; n_subs = 0; n_clrs = 0;
    if (op == 0) begin
      exp_L = b + 2; exp_res = (a * b) % 256; exp_rem = 0;
      exp_err = (a * b > 255); exp_adds = b; exp_subs = 0; exp_clrs = 1;
    end else if (b == 0) begin
      exp_L = 1; exp_res = 255; exp_rem = a; exp_err = 1;
      exp_adds = 0; exp_subs = 0; exp_clrs = 0;
    end else begin
      exp_L = a / b + 4; exp_res = a / b; exp_rem = a % b; exp_err = 0;
      exp_adds = 1; exp_subs = a / b; exp_clrs = 1;
    end
    exp_t0 = cyc + 1;
    exp_active = 1;
    @(negedge CLK);
    START = 1'b0;
    OP = 1'($urandom); OPA = 8'($urandom); OPB = 8'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_active && n < 600) begin
      @(negedge CLK);
      n++;
    end
    if (exp_active) begin
      chk("timeout", 1, 0);
      exp_active = 0;
    end
  endtask

  task automatic run(input int op, input int a, input int b,
                     input int pr, input int pm, input int pe, input int pl);
    pin_on = 1; pin_res = pr; pin_rem = pm; pin_err = pe; pin_lat = pl;
    start_txn(op, a, b);
    wait_done();
    pin_on = 0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);

    run(0, 6, 10, 60, 0, 0, 12);
    run(1, 60, 12, 5, 0, 0, 9);
    run(1, 63, 10, 6, 3, 0, 10);
    run(1, 5, 9, 0, 5, 0, 4);
    run(1, 7, 0, 255, 7, 1, 1);
    run(0, 20, 13, 4, 0, 1, 15);
    run(0, 9, 0, 0, 0, 0, 2);

    // START with other operands while busy must be ignored.
    pin_on = 1; pin_res = 150; pin_rem = 0; pin_err = 0; pin_lat = 52;
    start_txn(0, 3, 50);
    repeat (5) @(negedge CLK);
    OP = 1'b1; OPA = 8'd9; OPB = 8'd9; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done();
    pin_on = 0;

    // Abort mid-multiply; START alongside CLR must lose.
    repeat (2) @(negedge CLK);
    start_txn(0, 3, 50);
    while (cyc < exp_t0 + 19) @(negedge CLK);
    CLR = 1'b1; START = 1'b1; OP = 1'b0; OPA = 8'd1; OPB = 8'd1;
    @(negedge CLK);
    CLR = 1'b0; START = 1'b0;
    repeat (3) @(negedge CLK);
    run(0, 3, 7, 21, 0, 0, 9);

    for (int i = 0; i < 40; i++) begin
      int op, a, b;
      op = int'($urandom_range(1, 0));
      a  = int'($urandom_range(255, 0));
      if (op == 0)                       b = int'($urandom_range(20, 0));
      else if ($urandom_range(7, 0) == 0) b = 0;
      else                               b = int'($urandom_range(255, 1));
      start_txn(op, a, b);
      wait_done();
      if ($urandom_range(1, 0) == 1) repeat ($urandom_range(3, 1)) @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
